// File: rtl/ff_pattern_checker_if.sv
// ff_pattern_checker_if
//   Bundles the run-control and flip-flop test signals of ff_pattern_checker.
//   Signals:
//     start      - request a run (accepted only while the checker is idle)
//     q_in       - q output of the flip-flop under test
//     d_out      - data bit driven to the flip-flop d input
//     sclk_out   - slow clock driven to the flip-flop clk input
//     busy       - run in progress
//     done       - one-cycle end-of-run strobe
//     pass       - last run had zero mismatches
//     err_count  - mismatch count of the current or last run
//     bit_idx    - index of the bit under test (0 = MSB)
//   Modports:
//     master - the checker itself (drives stimulus and status)
//     slave  - board / bench side (drives start and the flip-flop q)
interface ff_pattern_checker_if #(
    parameter int PATTERN_W = 8
);
    localparam int CNT_W = $clog2(PATTERN_W + 1);
    localparam int BIT_W = $clog2(PATTERN_W);

    logic             start;
    logic             q_in;
    logic             d_out;
    logic             sclk_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [BIT_W-1:0] bit_idx;

    modport master (
        input  start, q_in,
        output d_out, sclk_out, busy, done, pass, err_count, bit_idx
    );

    modport slave (
        output start, q_in,
        input  d_out, sclk_out, busy, done, pass, err_count, bit_idx
    );
endinterface

// File: rtl/ff_pattern_checker.sv
// ff_pattern_checker
//   Stimulus generator and response checker for a single-bit D flip-flop.
//   For every pattern bit (MSB first): drive d_out, hold it SETUP_CYC cycles,
//   raise sclk_out for HIGH_CYC cycles, compare q_in against d_out on the last
//   high cycle, then hold sclk_out low for LOW_CYC cycles.
//   Ports:
//     clk       - system clock, rising edge
//     rst_n     - asynchronous active-low reset
//     bus       - ff_pattern_checker_if.master (start/q_in in, status and
//                 flip-flop stimulus out)
//     dbg_state - current FSM state (IDLE=0, SETUP=1, HIGH=2, LOW=3, DONE=4)
//
//   Handshake: start is a request that is accepted on a rising edge only when
//   the FSM is in IDLE; the accepting edge raises busy. Requests while busy or
//   in DONE are dropped, not queued. Completion is signalled by done, a
//   one-cycle strobe raised on the same edge that lowers busy and updates
//   pass; err_count and pass then hold until the next accepted start.
module ff_pattern_checker #(
    parameter int                      PATTERN_W = 8,
    parameter logic [PATTERN_W-1:0]    PATTERN   = 8'hA5,
    parameter int                      SETUP_CYC = 2,
    parameter int                      HIGH_CYC  = 2,
    parameter int                      LOW_CYC   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ff_pattern_checker_if.master   bus,
    output logic [2:0]             dbg_state
);
    localparam int BIT_W  = $clog2(PATTERN_W);
    localparam int PH_MAX = (SETUP_CYC > HIGH_CYC)
                          ? ((SETUP_CYC > LOW_CYC) ? SETUP_CYC : LOW_CYC)
                          : ((HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0]  HIGH_LAST  = PH_W'(HIGH_CYC - 1);
    localparam logic [PH_W-1:0]  LOW_LAST   = PH_W'(LOW_CYC - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(PATTERN_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state;
    logic [PH_W-1:0]       ph_cnt;
    // Remaining pattern, MSB aligned: bit [PATTERN_W-2] is the next bit to send.
    logic [PATTERN_W-1:0]  pat_sr;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ph_cnt        <= '0;
            pat_sr        <= '0;
            bus.d_out     <= 1'b0;
            bus.sclk_out  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= '0;
            bus.bit_idx   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    ph_cnt <= '0;
                    if (bus.start) begin
                        state         <= SETUP;
                        pat_sr        <= PATTERN;
                        bus.d_out     <= PATTERN[PATTERN_W-1];
                        bus.bit_idx   <= '0;
                        bus.err_count <= '0;
                        bus.pass      <= 1'b0;
                        bus.busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    bus.sclk_out <= 1'b0;
                    if (ph_cnt == SETUP_LAST) begin
                        state        <= HIGH;
                        ph_cnt       <= '0;
                        bus.sclk_out <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (ph_cnt == HIGH_LAST) begin
                        // The DUT captured d_out on the rising sclk_out edge;
                        // its q has settled by the last high cycle.
                        if (bus.q_in != bus.d_out)
                            bus.err_count <= bus.err_count + 1'b1;
                        state        <= LOW;
                        ph_cnt       <= '0;
                        bus.sclk_out <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (ph_cnt == LOW_LAST) begin
                        ph_cnt <= '0;
                        if (bus.bit_idx == LAST_BIT) begin
                            state <= DONE;
                        end else begin
                            state       <= SETUP;
                            bus.bit_idx <= bus.bit_idx + 1'b1;
                            bus.d_out   <= pat_sr[PATTERN_W-2];
                            pat_sr      <= pat_sr << 1;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Status is published on the exit edge, so done is seen
                    // during the single IDLE cycle that separates runs.
                    state     <= IDLE;
                    ph_cnt    <= '0;
                    bus.done  <= 1'b1;
                    bus.busy  <= 1'b0;
                    bus.pass  <= (bus.err_count == '0);
                    bus.d_out <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ph_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ff_pattern_checker.sv
module tb_ff_pattern_checker;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int q_mode = 0;   // 0 loopback DFF, 1 tied 0, 2 tied 1, 3 inverting DFF

    // ---------------- DUT A: defaults ----------------
    ff_pattern_checker_if #(.PATTERN_W(8)) a_bus ();
    logic [2:0] a_dbg;
    logic       q_a = 1'b0;

    ff_pattern_checker dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (a_bus),
        .dbg_state (a_dbg)
    );

    always @(posedge a_bus.sclk_out or negedge rst_n)
        if (!rst_n) q_a <= 1'b0;
        else        q_a <= a_bus.d_out;

    assign a_bus.q_in = (q_mode == 0) ? q_a :
                        (q_mode == 1) ? 1'b0 :
                        (q_mode == 2) ? 1'b1 : ~q_a;

    // ---------------- DUT B: short timing, 4-bit pattern ----------------
    ff_pattern_checker_if #(.PATTERN_W(4)) b_bus ();
    logic [2:0] b_dbg;
    logic       q_b = 1'b0;

    ff_pattern_checker #(
        .PATTERN_W (4),
        .PATTERN   (4'b1100),
        .SETUP_CYC (1),
        .HIGH_CYC  (1),
        .LOW_CYC   (1)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (b_bus),
        .dbg_state (b_dbg)
    );

    always @(posedge b_bus.sclk_out or negedge rst_n)
        if (!rst_n) q_b <= 1'b0;
        else        q_b <= b_bus.d_out;

    assign b_bus.q_in = q_b;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- driver: one run on DUT A ----------------
    // poke_bit >= 0 pulses start once while bit_idx equals it; hold keeps start
    // high through the whole run and leaves it high on return.
    task automatic run_a(input int mode, input int exp_err, input int exp_pass,
                         input int poke_bit, input bit hold, input string tag);
        int bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        logic [0:0] exp_q[$];
        logic [2:0] idx_q[$];
        int  edges = 0, pulses = 0, hi_cycles = 0, first_rise = -1, last_rise = -1;
        bit  prev_sclk, poked = 0;
        logic [0:0] eb;
        logic [2:0] ei;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(1'(bits[i]));
            idx_q.push_back(3'(i));
        end
        q_mode = mode;
        @(posedge clk); #1 a_bus.start = 1'b1;
        @(posedge clk); #1 a_bus.start = hold;
        check({tag, "_accept_busy"}, a_bus.busy, 1);
        check({tag, "_accept_idx"}, a_bus.bit_idx, 0);
        check({tag, "_accept_err"}, a_bus.err_count, 0);
        check({tag, "_accept_d"}, a_bus.d_out, 1);
        prev_sclk = a_bus.sclk_out;
        while (a_bus.done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (a_bus.sclk_out) hi_cycles++;
            if (a_bus.sclk_out && !prev_sclk) begin
                if (pulses == 0) first_rise = edges;
                last_rise = edges;
                pulses++;
                if (exp_q.size() > 0) begin
                    eb = exp_q.pop_front();
                    ei = idx_q.pop_front();
                    check({tag, "_d_seq"}, a_bus.d_out, eb);
                    check({tag, "_idx_seq"}, a_bus.bit_idx, ei);
                end else begin
                    check({tag, "_pulse_count_over"}, pulses, 8);
                end
            end
            prev_sclk = a_bus.sclk_out;
            if (!poked && poke_bit >= 0 && int'(a_bus.bit_idx) == poke_bit) begin
                a_bus.start = 1'b1;
                poked = 1;
            end else begin
                a_bus.start = hold;
            end
        end
        check({tag, "_done_edge"}, edges, 49);
        check({tag, "_done_busy"}, a_bus.busy, 0);
        check({tag, "_err"}, a_bus.err_count, exp_err);
        check({tag, "_pass"}, a_bus.pass, exp_pass);
        check({tag, "_pulses"}, pulses, 8);
        check({tag, "_hi_cycles"}, hi_cycles, 16);
        check({tag, "_first_rise"}, first_rise, 2);
        check({tag, "_last_rise"}, last_rise, 44);
        check({tag, "_left_in_q"}, exp_q.size(), 0);
        if (!hold) begin
            @(posedge clk); #1;
            check({tag, "_done_one_cycle"}, a_bus.done, 0);
            check({tag, "_idle_busy"}, a_bus.busy, 0);
            check({tag, "_err_hold"}, a_bus.err_count, exp_err);
        end
    endtask

    // ---------------- driver: one loopback run on DUT B ----------------
    task automatic run_b();
        int bits[4] = '{1, 1, 0, 0};
        int rises[4] = '{1, 4, 7, 10};
        int edges = 0, pulses = 0;
        bit prev_sclk;
        @(posedge clk); #1 b_bus.start = 1'b1;
        @(posedge clk); #1 b_bus.start = 1'b0;
        check("b_accept_busy", b_bus.busy, 1);
        prev_sclk = b_bus.sclk_out;
        while (b_bus.done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (b_bus.sclk_out && !prev_sclk) begin
                if (pulses < 4) begin
                    check("b_rise_edge", edges, rises[pulses]);
                    check("b_d_seq", b_bus.d_out, bits[pulses]);
                end
                pulses++;
            end
            prev_sclk = b_bus.sclk_out;
        end
        check("b_done_edge", edges, 13);
        check("b_pulses", pulses, 4);
        check("b_err", b_bus.err_count, 0);
        check("b_pass", b_bus.pass, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int    mode;
        int    exp_err;
        int    exp_pass;
        string tag;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int found;
        vecs[0] = '{0, 0, 1, "loopback"};
        vecs[1] = '{1, 4, 0, "tied0"};
        vecs[2] = '{2, 4, 0, "tied1"};
        vecs[3] = '{3, 8, 0, "invert"};

        a_bus.start = 1'b0;
        b_bus.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_d_out", a_bus.d_out, 0);
        check("rst_sclk", a_bus.sclk_out, 0);
        check("rst_busy", a_bus.busy, 0);
        check("rst_done", a_bus.done, 0);
        check("rst_pass", a_bus.pass, 0);
        check("rst_err", a_bus.err_count, 0);
        check("rst_idx", a_bus.bit_idx, 0);
        check("rst_state", a_dbg, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            run_a(vecs[i].mode, vecs[i].exp_err, vecs[i].exp_pass, -1, 1'b0, vecs[i].tag);

        // start while busy: no restart, done timing unchanged
        run_a(0, 0, 1, 2, 1'b0, "poke");

        // start held across DONE: next run begins after one IDLE cycle
        run_a(1, 4, 0, -1, 1'b1, "hold");
        @(posedge clk); #1;
        check("hold_restart_busy", a_bus.busy, 1);
        check("hold_restart_err", a_bus.err_count, 0);
        check("hold_restart_done", a_bus.done, 0);
        check("hold_restart_state", a_dbg, 1);
        a_bus.start = 1'b0;
        found = 0;
        for (int e = 0; e < 100 && !found; e++) begin
            @(posedge clk); #1;
            if (a_bus.done) found = 1;
        end
        check("hold_second_done_seen", found, 1);
        check("hold_second_err", a_bus.err_count, 4);
        @(posedge clk); #1;

        // reset during HIGH of bit 3
        q_mode = 0;
        @(posedge clk); #1 a_bus.start = 1'b1;
        @(posedge clk); #1 a_bus.start = 1'b0;
        found = 0;
        for (int e = 0; e < 100 && !found; e++) begin
            @(posedge clk); #1;
            if (a_bus.bit_idx == 3'd3 && a_bus.sclk_out) found = 1;
        end
        check("midrst_reach_bit3", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_d_out", a_bus.d_out, 0);
        check("midrst_sclk", a_bus.sclk_out, 0);
        check("midrst_busy", a_bus.busy, 0);
        check("midrst_idx", a_bus.bit_idx, 0);
        check("midrst_err", a_bus.err_count, 0);
        check("midrst_state", a_dbg, 0);
        @(posedge clk); #1;
        check("midrst_held_busy", a_bus.busy, 0);
        rst_n = 1'b1;
        run_a(0, 0, 1, -1, 1'b0, "after_rst");

        // short-timing 4-bit instance
        run_b();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
